// File: rtl/quad_decoder_if.sv
// quad_decoder_if -- signal bundle between a quadrature decoder and its user.
// The user drives the encoder channels and the two clear strobes; the decoder
// returns position, speed (period), direction, step strobe and error flag.
// When QUAD_DECODER_INDEX_EN is defined the bundle also carries the z index
// channel and the sticky index_seen flag.
interface quad_decoder_if #(
  parameter int CNT_W = 32,
  parameter int PER_W = 32
);
  logic                    a;
  logic                    b;
  logic                    reset_counts;
  logic                    clear_error;
  logic signed [CNT_W-1:0] total_counts;
  logic        [PER_W-1:0] period;
  logic                    direction;
  logic                    step;
  logic                    error;
`ifdef QUAD_DECODER_INDEX_EN
  logic                    z;
  logic                    index_seen;

  modport master (
    output a, b, z, reset_counts, clear_error,
    input  total_counts, period, direction, step, error, index_seen
  );
  modport slave (
    input  a, b, z, reset_counts, clear_error,
    output total_counts, period, direction, step, error, index_seen
  );
`else
  modport master (
    output a, b, reset_counts, clear_error,
    input  total_counts, period, direction, step, error
  );
  modport slave (
    input  a, b, reset_counts, clear_error,
    output total_counts, period, direction, step, error
  );
`endif
endinterface

// File: rtl/quad_decoder.sv
// quad_decoder -- filtered quadrature decoder with position count, step
// period measurement and illegal-transition detection.
//
// Pipeline (edge 0 = first clk_50 edge that samples a new input level):
//   edge 0          sync stage 1
//   edge 1          sync stage 2
//   edge FILT_LEN+1 glitch filter accepts the level
//   edge FILT_LEN+2 decode stage captures the filtered pair
//   edge FILT_LEN+3 count / direction / step / error update
//
// Optional feature: define QUAD_DECODER_INDEX_EN to add the z index channel,
// which zeroes the count on a filtered rising edge and sets index_seen.
// FILT_LEN is meaningful in the range 1..15 (4-bit run counter).
module quad_decoder #(
  parameter int CNT_W    = 32,
  parameter int PER_W    = 32,
  parameter int FILT_LEN = 3,
  parameter int MODE     = 2
) (
  input  logic          clk_50,
  input  logic          reset,
  quad_decoder_if.slave qif
);

  localparam int CH_A = 0;
  localparam int CH_B = 1;
`ifdef QUAD_DECODER_INDEX_EN
  localparam int CH_Z = 2;
  localparam int NCH  = 3;
`else
  localparam int NCH  = 2;
`endif
  // Priming covers FILT_LEN+2 edges after reset; vld_pipe[STAGES] marks its end.
  localparam int               STAGES   = FILT_LEN + 1;
  localparam logic [3:0]       RUN_LAST = 4'(FILT_LEN - 1);
  localparam logic [PER_W-1:0] PER_MAX  = '1;
  localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync1_q;
  logic [NCH-1:0]   sync2_q;
  logic [NCH-1:0]   filt;
  logic [NCH-1:0]   cur_q;
  logic [NCH-1:0]   prv_q;
  logic [STAGES:0]  vld_pipe;
  logic             priming;

  logic [1:0]       delta;
  logic             legal;
  logic             illegal;
  logic             a_leads;
  logic             counted;

  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;
  logic             step_q;
  logic             err_q;
  logic [PER_W-1:0] timer_q;
  logic [PER_W-1:0] per_q;
  logic             first_seen_q;

  assign raw[CH_A] = qif.a;
  assign raw[CH_B] = qif.b;
`ifdef QUAD_DECODER_INDEX_EN
  logic z_rise;
  logic idx_q;
  assign raw[CH_Z] = qif.z;
`endif

  assign priming = ~vld_pipe[STAGES];

  // Two-flop synchronisers plus the post-reset priming shift register.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      vld_pipe <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end
  end

  // One glitch filter per channel.
  for (genvar c = 0; c < NCH; c++) begin : g_filt
    logic       lvl_q;
    logic [3:0] run_q;

    // Adopt a new level only after FILT_LEN consecutive disagreeing samples;
    // during priming the level follows the synchroniser directly.
    always_ff @(posedge clk_50) begin
      if (reset) begin
        lvl_q <= 1'b0;
        run_q <= '0;
      end else if (priming) begin
        lvl_q <= sync2_q[c];
        run_q <= '0;
      end else if (sync2_q[c] == lvl_q) begin
        run_q <= '0;
      end else if (run_q == RUN_LAST) begin
        lvl_q <= sync2_q[c];
        run_q <= '0;
      end else begin
        run_q <= run_q + 4'd1;
      end
    end

    assign filt[c] = lvl_q;
  end

  // Decode stage: current and previous filtered state. While priming both
  // load the same value so the first real state never looks like a move.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      cur_q <= '0;
      prv_q <= '0;
    end else if (priming) begin
      cur_q <= filt;
      prv_q <= filt;
    end else begin
      cur_q <= filt;
      prv_q <= cur_q;
    end
  end

  // Position of an {a,b} pair around the cycle 00->10->11->01; a step of +1
  // along it is A-leads, -1 is B-leads, 2 means both bits flipped.
  function automatic logic [1:0] phase(input logic av, input logic bv);
    return {bv, av ^ bv};
  endfunction

  assign delta = phase(cur_q[CH_A], cur_q[CH_B]) - phase(prv_q[CH_A], prv_q[CH_B]);

  // Classify the move and apply the decoding mode's counting rule.
  always_comb begin
    legal   = 1'b0;
    illegal = 1'b0;
    a_leads = 1'b0;
    counted = 1'b0;
    if (!priming) begin
      legal   = delta[0];
      illegal = (delta == 2'd2);
      a_leads = (delta == 2'd1);
    end
    case (MODE)
      0:       counted = legal & cur_q[CH_A] & ~prv_q[CH_A];
      1:       counted = legal & (cur_q[CH_A] ^ prv_q[CH_A]);
      default: counted = legal;
    endcase
  end

`ifdef QUAD_DECODER_INDEX_EN
  assign z_rise = ~priming & cur_q[CH_Z] & ~prv_q[CH_Z];
`endif

  // Position count, direction, step strobe and sticky error. reset_counts
  // beats the index, which beats a step; an illegal move beats clear_error.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      step_q <= counted;
      if (counted) dir_q <= a_leads;
      if (qif.reset_counts) cnt_q <= '0;
`ifdef QUAD_DECODER_INDEX_EN
      else if (z_rise)      cnt_q <= '0;
`endif
      else if (counted)     cnt_q <= a_leads ? cnt_q - CNT_ONE : cnt_q + CNT_ONE;
      if (illegal)              err_q <= 1'b1;
      else if (qif.clear_error) err_q <= 1'b0;
    end
  end

  // Step-to-step timer. The first counted step after reset only restarts it.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      timer_q      <= '0;
      per_q        <= '0;
      first_seen_q <= 1'b0;
    end else if (counted) begin
      timer_q      <= PER_ONE;
      first_seen_q <= 1'b1;
      if (first_seen_q) per_q <= timer_q;
    end else if (timer_q != PER_MAX) begin
      timer_q <= timer_q + PER_ONE;
    end
  end

`ifdef QUAD_DECODER_INDEX_EN
  // Sticky index flag; reset_counts clears it.
  always_ff @(posedge clk_50) begin
    if (reset)                 idx_q <= 1'b0;
    else if (qif.reset_counts) idx_q <= 1'b0;
    else if (z_rise)           idx_q <= 1'b1;
  end
  assign qif.index_seen = idx_q;
`endif

  assign qif.total_counts = cnt_q;
  assign qif.direction    = dir_q;
  assign qif.step         = step_q;
  assign qif.error        = err_q;
  // A saturated timer means the shaft has stalled: report all-ones at once.
  assign qif.period       = (timer_q == PER_MAX) ? PER_MAX : per_q;

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the signed position count.
REQ-002 SHALL have parameter PER_W, default 32: width of the period measurement.
REQ-003 SHALL have parameter FILT_LEN, default 3: number of consecutive equal samples needed to accept a new input level (range 1..15).
REQ-004 SHALL have parameter MODE, default 2: 0 = x1, 1 = x2, 2 = x4 decoding.
REQ-005 clk_50  input  1  sole clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 a, b  input  1 each  asynchronous quadrature channels.
REQ-008 reset_counts  input  1  synchronous clear of total_counts.
REQ-009 clear_error  input  1  synchronous clear of error.
REQ-010 total_counts  output  CNT_W  signed position count.
REQ-011 period  output  PER_W  clk_50 cycles between the last two counted steps.
REQ-012 direction  output  1  1 = A leads B (count decrements); 0 = B leads A (count increments).
REQ-013 step  output  1  one-cycle pulse on every counted step.
REQ-014 error  output  1  sticky flag for an illegal transition.

Function
REQ-015 SHALL synchronise a and b through two flops each.
REQ-016 Each channel's filtered level SHALL change only after FILT_LEN consecutive synchronised samples that differ from the current filtered level; any shorter excursion SHALL be ignored.
REQ-017 Decoding SHALL use the filtered {a,b} pair: the sequence 00->10->11->01->00 is A-leads (count -1, direction=1); the reverse sequence is count +1, direction=0.
REQ-018 MODE 2 SHALL count every legal transition; MODE 1 SHALL count only A-level changes; MODE 0 SHALL count only rising A.
REQ-019 If both filtered bits change in the same cycle, the block SHALL set error, leave total_counts and direction unchanged, assert no step, and adopt the new state.
REQ-020 total_counts SHALL wrap modulo 2^CNT_W with no saturation.
REQ-021 total_counts, direction and step SHALL update FILT_LEN+3 cycles after the first clk_50 edge that samples a new stable input level.
REQ-022 A PER_W timer SHALL increment each cycle, saturating at all-ones; on a counted step, period <= timer and timer <= 1.
REQ-023 When the timer reaches all-ones, period SHALL become all-ones (stall indication) in the same cycle.
REQ-024 The first counted step after reset SHALL only restart the timer; period SHALL stay 0.
REQ-025 reset_counts SHALL set total_counts to 0 on the next edge and wins over a coincident step; it SHALL NOT affect period, direction or error.
REQ-026 A coincident illegal transition SHALL win over clear_error, leaving error = 1.

Reset
REQ-027 While reset = 1, all outputs SHALL be 0 and the synchronisers, filters, timer and internal state SHALL be cleared.
REQ-028 After reset deasserts, the first filtered state SHALL load without generating step, a count change or error (priming lasts FILT_LEN+2 cycles).

Configuration
REQ-029 Macro QUAD_DECODER_INDEX_EN defined: SHALL add input z (index) and output index_seen; z SHALL be synchronised and filtered like a and b.
REQ-030 With QUAD_DECODER_INDEX_EN, a filtered rising z SHALL set total_counts to 0, overriding a coincident step but not reset_counts, and SHALL set index_seen sticky; reset_counts clears index_seen.
REQ-031 Macro undefined: the z and index_seen ports SHALL be absent and there SHALL be no index logic.

Verification
REQ-032 MODE 2, 8 A-leads cycles with 100 clk_50 per edge -> total_counts = -32, direction = 1, period = 100, 32 step pulses.
REQ-033 Then 8 B-leads cycles -> total_counts = 0, direction = 0; a 2-cycle glitch on a (FILT_LEN=3) -> no step, count unchanged.
REQ-034 a and b toggled on the same edge -> error = 1, count unchanged; clear_error pulse -> error = 0.
REQ-035 CNT_W=8, 128 increments from 0 -> total_counts = 8'h80 (-128); PER_W=8, no edges for 255 cycles -> period = 8'hFF.
REQ-036 QUAD_DECODER_INDEX_EN, count at +5, z pulse longer than FILT_LEN -> total_counts = 0, index_seen = 1; reset_counts -> index_seen = 0.
